// File: rtl/auth_pkg.sv
// rtl/auth_pkg.sv - shared types and constants for the password session controller
package auth_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_FAIL,
        S_LOCKED,
        S_UNLOCKED,
        S_PROG,
        S_COMMIT
    } state_t;

    localparam logic [1:0] SYM_T = 2'd0;
    localparam logic [1:0] SYM_D = 2'd1;
    localparam logic [1:0] SYM_L = 2'd2;
    localparam logic [1:0] SYM_R = 2'd3;

    // Segments gfedcba, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/auth_tick_timer.sv
// rtl/auth_tick_timer.sv - tick-strobe counter with clear, enable and terminal-count compare
module auth_tick_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic         tick,
    input  logic [W-1:0] term,
    output logic         done
);

    logic [W-1:0] cnt;

    // Clear has priority over a coincident tick, so a press in the same cycle drops the tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && tick && (cnt != term)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign done = enable && (cnt == term);

endmodule

// File: rtl/auth_session_ctrl.sv
// rtl/auth_session_ctrl.sv - password entry sessions, failure lockout and reprogramming
module auth_session_ctrl
    import auth_pkg::*;
#(
    parameter int                  PW_LEN        = 4,
    parameter logic [2*PW_LEN-1:0] DEFAULT_PW    = 8'b11_10_10_00,
    parameter int                  MAX_FAILS     = 3,
    parameter int                  PRESS_TIMEOUT = 30,
    parameter int                  LOCKOUT_TICKS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_pulse,
    input  logic       tick,
    input  logic       prog_req,
    input  logic       lock_req,
    output logic       unlocked,
    output logic       locked_out,
    output logic [1:0] fail_cnt,
    output logic [6:0] SSG_D,
    output logic [2:0] SSG_EN
);

    localparam int IDX_W = (PW_LEN > 1) ? $clog2(PW_LEN) : 1;
    localparam int TW    = $clog2(((PRESS_TIMEOUT > LOCKOUT_TICKS) ? PRESS_TIMEOUT : LOCKOUT_TICKS) + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PW_LEN - 1);

    state_t              state, state_next;
    logic [IDX_W-1:0]    idx;
    logic                mismatch;
    logic [2*PW_LEN-1:0] pw, shadow;
    logic [1:0]          fail_q;
    logic [2:0]          fail_inc;
    logic [1:0]          sym;
    logic                press, sym_valid, sym_bad;
    logic                tmr_clear, tmr_enable, tmr_done;
    logic [TW-1:0]       tmr_term;

    assign press     = |btn_pulse;
    assign sym_valid = $onehot(btn_pulse);
    assign sym_bad   = !sym_valid || (sym != pw[{idx, 1'b0} +: 2]);
    assign fail_inc  = {1'b0, fail_q} + 3'd1;

    always_comb begin
        sym = SYM_T;
        case (btn_pulse)
            4'b0010: sym = SYM_D;
            4'b0100: sym = SYM_L;
            4'b1000: sym = SYM_R;
            default: sym = SYM_T;
        endcase
    end

    // Presses only restart the timer where they are meaningful, so LOCKED cannot be extended
    assign tmr_enable = (state == S_ENTRY) || (state == S_PROG) || (state == S_LOCKED);
    assign tmr_term   = (state == S_LOCKED) ? TW'(LOCKOUT_TICKS) : TW'(PRESS_TIMEOUT);
    assign tmr_clear  = (state_next != state) ||
                        (press && ((state == S_IDLE) || (state == S_ENTRY) || (state == S_PROG)));

    auth_tick_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .tick   (tick),
        .term   (tmr_term),
        .done   (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (press) state_next = S_ENTRY;
            S_ENTRY: begin
                if (press) begin
                    if (idx == LAST_IDX) state_next = S_CHECK;
                end else if (tmr_done) begin
                    state_next = S_FAIL;
                end
            end
            S_CHECK:    state_next = mismatch ? S_FAIL : S_UNLOCKED;
            S_FAIL:     state_next = (fail_inc >= 3'(MAX_FAILS)) ? S_LOCKED : S_IDLE;
            S_LOCKED:   if (tmr_done) state_next = S_IDLE;
            S_UNLOCKED: begin
                if (lock_req)      state_next = S_IDLE;
                else if (prog_req) state_next = S_PROG;
            end
            S_PROG: begin
                if (press) begin
                    if (!sym_valid)           state_next = S_UNLOCKED;
                    else if (idx == LAST_IDX) state_next = S_COMMIT;
                end else if (tmr_done) begin
                    state_next = S_UNLOCKED;
                end
            end
            S_COMMIT:   state_next = S_UNLOCKED;
            default:    state_next = S_IDLE;
        endcase
    end

    // Mismatch is sticky across the whole entry so the failing position is never revealed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            mismatch <= 1'b0;
            pw       <= DEFAULT_PW;
            shadow   <= '0;
            fail_q   <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    idx      <= press ? IDX_W'(1) : '0;
                    mismatch <= sym_bad;
                end
                S_ENTRY: if (press) begin
                    idx      <= idx + IDX_W'(1);
                    mismatch <= mismatch | sym_bad;
                end
                S_CHECK:    if (!mismatch) fail_q <= 2'd0;
                S_FAIL:     fail_q <= (fail_inc >= 3'(MAX_FAILS)) ? 2'(MAX_FAILS) : fail_inc[1:0];
                S_LOCKED:   if (tmr_done) fail_q <= 2'd0;
                S_UNLOCKED: idx <= '0;
                S_PROG: if (press && sym_valid) begin
                    shadow[{idx, 1'b0} +: 2] <= sym;
                    idx                      <= idx + IDX_W'(1);
                end
                S_COMMIT:   pw <= shadow;
                default:    ;
            endcase
        end
    end

    assign unlocked   = (state == S_UNLOCKED);
    assign locked_out = (state == S_LOCKED);
    assign fail_cnt   = fail_q;
    assign SSG_EN     = 3'b111;

    always_comb begin
        SSG_D = SEG_BLANK;
        case (state)
            S_IDLE:           SSG_D = SEG_0;
            S_ENTRY, S_PROG:  SSG_D = seg_digit(4'(idx));
            S_UNLOCKED:       SSG_D = SEG_9;
            S_LOCKED:         SSG_D = SEG_E;
            default:          SSG_D = SEG_BLANK;
        endcase
    end

endmodule
